branch_sequencer: RTL and testbench

Hardware control sequencer for the conditional-branch instruction class. It drives the fetch micro-steps T0–T2 and the branch micro-steps T3–T6 that the datapath needs, so a bench no longer has to toggle those strobes by hand. It evaluates all four branch conditions (zero, nonzero, plus, minus) internally and gates the PC load in T6 on the result. It sits beside the datapath: it reads the IR and the bus, and drives the datapath's control strobes directly.

---
 rtl/branch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Fetch + conditional-branch control sequencer: drives T0-T6 strobes and gates PCin in T6.
// Optional macro BRANCH_SKIP_NOT_TAKEN_EN: not-taken branches jump T3 -> DONE.
module branch_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [4:0]  BRANCH_OP  = 5'b10010,
    parameter int unsigned C2_LSB     = 19
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  start,
    input  logic                  mem_ready,
    input  logic [31:0]           ir_in,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic                  PCout,
    output logic                  MARin,
    output logic                  Read,
    output logic                  MDRin,
    output logic                  IncPC,
    output logic                  IRin,
    output logic                  Gra,
    output logic                  Rout,
    output logic                  CONin,
    output logic                  Yin,
    output logic                  Cout,
    output logic                  Zin,
    output logic                  ZLOout,
    output logic                  PCin,
    output logic                  busy,
    output logic                  done,
    output logic                  taken,
    output logic                  illegal
);

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
        StT6   = 4'd7,
        StDone = 4'd8
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic       r_con;
    logic       r_illegal;
    logic [1:0] w_c2;
    logic       w_opcode_ok;
    logic       w_cond;
    logic       w_ir_unused;

    assign w_c2        = ir_in[C2_LSB+1:C2_LSB];
    assign w_opcode_ok = (ir_in[31:27] == BRANCH_OP);
    // Only the opcode and C2 fields are decoded here; the rest belongs to the datapath.
    assign w_ir_unused = ^ir_in;

    always_comb begin
        w_cond = 1'b0;
        case (w_c2)
            2'b00:   w_cond = (bus_in == '0);
            2'b01:   w_cond = (bus_in != '0);
            2'b10:   w_cond = ~bus_in[DATA_WIDTH-1];
            2'b11:   w_cond = bus_in[DATA_WIDTH-1];
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StT0;
                end
            end
            StT0: w_state_next = StT1;
            StT1: begin
                if (mem_ready) begin
                    w_state_next = StT2;
                end
            end
            StT2: w_state_next = StT3;
            StT3: begin
                if (!w_opcode_ok) begin
                    w_state_next = StIdle;
                end else begin
`ifdef BRANCH_SKIP_NOT_TAKEN_EN
                    w_state_next = w_cond ? StT4 : StDone;
`else
                    w_state_next = StT4;
`endif
                end
            end
            StT4:    w_state_next = StT5;
            StT5:    w_state_next = StT6;
            StT6:    w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state   <= StIdle;
            r_con     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_illegal <= (r_state == StT3) && !w_opcode_ok;
            // An illegal opcode leaves the previous branch result visible on taken.
            if ((r_state == StT3) && w_opcode_ok) begin
                r_con <= w_cond;
            end
        end
    end

    always_comb begin
        PCout  = 1'b0;
        MARin  = 1'b0;
        Read   = 1'b0;
        MDRin  = 1'b0;
        IncPC  = 1'b0;
        IRin   = 1'b0;
        Gra    = 1'b0;
        Rout   = 1'b0;
        CONin  = 1'b0;
        Yin    = 1'b0;
        Cout   = 1'b0;
        Zin    = 1'b0;
        ZLOout = 1'b0;
        PCin   = 1'b0;
        done   = 1'b0;
        case (r_state)
            StT0: begin
                PCout = 1'b1;
                MARin = 1'b1;
            end
            StT1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                PCin  = 1'b1;
                IncPC = 1'b1;
            end
            StT2: IRin = 1'b1;
            StT3: begin
                Gra   = 1'b1;
                Rout  = 1'b1;
                CONin = 1'b1;
            end
            StT4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            StT5: begin
                Cout = 1'b1;
                Zin  = 1'b1;
            end
            StT6: begin
                ZLOout = 1'b1;
                PCin   = r_con;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (r_state != StIdle);
    assign taken   = r_con;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: per-cycle reference model plus directed sequences.
module tb_branch_sequencer;

    localparam int unsigned DW        = 32;
    localparam logic [4:0]  BOP       = 5'b10010;
    localparam int unsigned C2L       = 19;
`ifdef BRANCH_SKIP_NOT_TAKEN_EN
    localparam bit          SKIP      = 1'b1;
`else
    localparam bit          SKIP      = 1'b0;
`endif
    localparam int          LAT_NT    = SKIP ? 5 : 8;

    logic          Clock = 1'b0;
    logic          Clear;
    logic          start;
    logic          mem_ready;
    logic [31:0]   ir_in;
    logic [DW-1:0] bus_in;
    logic PCout, MARin, Read, MDRin, IncPC, IRin, Gra, Rout, CONin;
    logic Yin, Cout, Zin, ZLOout, PCin, busy, done, taken, illegal;

    int n_checks = 0;
    int n_errors = 0;

    branch_sequencer #(
        .DATA_WIDTH(DW),
        .BRANCH_OP (BOP),
        .C2_LSB    (C2L)
    ) dut (
        .Clock    (Clock),
        .Clear    (Clear),
        .start    (start),
        .mem_ready(mem_ready),
        .ir_in    (ir_in),
        .bus_in   (bus_in),
        .PCout    (PCout),
        .MARin    (MARin),
        .Read     (Read),
        .MDRin    (MDRin),
        .IncPC    (IncPC),
        .IRin     (IRin),
        .Gra      (Gra),
        .Rout     (Rout),
        .CONin    (CONin),
        .Yin      (Yin),
        .Cout     (Cout),
        .Zin      (Zin),
        .ZLOout   (ZLOout),
        .PCin     (PCin),
        .busy     (busy),
        .done     (done),
        .taken    (taken),
        .illegal  (illegal)
    );

    always #5 Clock = ~Clock;

    function automatic logic [17:0] act_vec();
        return {PCout, MARin, Read, MDRin, IncPC, IRin, Gra, Rout, CONin,
                Yin, Cout, Zin, ZLOout, PCin, busy, done, taken, illegal};
    endfunction

    // Reference: step 0 = idle, 1..7 = T0..T6, 8 = done.
    int m_step = 0;
    bit m_con  = 1'b0;
    bit m_ill  = 1'b0;

    function automatic bit ref_cond(logic [1:0] c2, logic [DW-1:0] b);
        case (c2)
            2'd0:    return b == 0;
            2'd1:    return b != 0;
            2'd2:    return !($signed(b) < 0);
            default: return $signed(b) < 0;
        endcase
    endfunction

    function automatic logic [17:0] model_vec(int step, bit con, bit ill);
        logic [17:0] v;
        v = '0;
        case (step)
            1: v[17:16] = 2'b11;
            2: begin v[15:13] = 3'b111; v[4] = 1'b1; end
            3: v[12] = 1'b1;
            4: v[11:9] = 3'b111;
            5: begin v[17] = 1'b1; v[8] = 1'b1; end
            6: v[7:6] = 2'b11;
            7: begin v[5] = 1'b1; v[4] = con; end
            default: ;
        endcase
        v[3] = (step != 0);
        v[2] = (step == 8);
        v[1] = con;
        v[0] = ill;
        return v;
    endfunction

    always @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            m_step <= 0;
            m_con  <= 1'b0;
            m_ill  <= 1'b0;
        end else begin
            m_ill <= 1'b0;
            case (m_step)
                0: if (start) m_step <= 1;
                2: if (mem_ready) m_step <= 3;
                4: begin
                    if (ir_in[31:27] != BOP) begin
                        m_ill  <= 1'b1;
                        m_step <= 0;
                    end else begin
                        m_con  <= ref_cond(ir_in[C2L +: 2], bus_in);
                        m_step <= (SKIP && !ref_cond(ir_in[C2L +: 2], bus_in)) ? 8 : 5;
                    end
                end
                8:       m_step <= 0;
                default: m_step <= m_step + 1;
            endcase
        end
    end

    always @(negedge Clock) begin
        logic [17:0] a, e;
        a = act_vec();
        e = model_vec(m_step, m_con, m_ill);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL cycle_compare t=%0t step=%0d actual=%b expected=%b",
                     $time, m_step, a, e);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(logic [4:0] op, logic [1:0] c2);
        logic [31:0] ir;
        ir = 32'h0;
        ir[31:27] = op;
        ir[26:23] = 4'd3;
        ir[C2L +: 2] = c2;
        return ir;
    endfunction

    // Runs one start pulse; lat counts cycles from start to the done/illegal cycle.
    task automatic run_seq(input logic [31:0] ir, input logic [DW-1:0] bus, input int stall,
                           input bit extra_start, output int lat, output bit saw_done,
                           output bit saw_ill, output int reads, output bit busy_end);
        int cnt;
        bit fin;
        @(negedge Clock);
        ir_in     = ir;
        bus_in    = bus;
        start     = 1'b1;
        mem_ready = (stall == 0);
        @(negedge Clock);
        start = 1'b0;
        cnt   = 1;
        fin   = 1'b0;
        reads = 0;
        while (!fin && cnt <= 40) begin
            if (Read) reads++;
            if (done || illegal) begin
                fin = 1'b1;
            end else begin
                @(negedge Clock);
                cnt++;
                if (cnt >= stall + 2) mem_ready = 1'b1;
                start = extra_start && (cnt == 3);
            end
        end
        if (!fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL seq_timeout actual=none expected=done_or_illegal");
        end
        lat      = cnt;
        saw_done = done;
        saw_ill  = illegal;
        busy_end = busy;
        mem_ready = 1'b1;
        if (extra_start && saw_done) begin
            start = 1'b1;
            @(negedge Clock);
            start = 1'b0;
            check("idle_after_done", {31'd0, busy}, 32'd0);
            @(negedge Clock);
            check("start_in_done_ignored", {31'd0, busy}, 32'd0);
        end else begin
            @(negedge Clock);
        end
    endtask

    int lat, reads;
    bit sd, si, be;

    initial begin
        Clear = 1'b1;
        start = 1'b0;
        mem_ready = 1'b1;
        ir_in = 32'h0;
        bus_in = '0;
        repeat (2) @(negedge Clock);
        check("reset_outputs", {14'd0, act_vec()}, 32'd0);
        Clear = 1'b0;

        // 1: zero condition taken
        run_seq(mk_ir(BOP, 2'b00), 32'h0, 0, 1'b0, lat, sd, si, reads, be);
        check("t1_latency", lat, 8);
        check("t1_done", {31'd0, sd}, 32'd1);
        check("t1_taken", {31'd0, taken}, 32'd1);

        // 2: nonzero
        run_seq(mk_ir(BOP, 2'b01), 32'd5, 0, 1'b0, lat, sd, si, reads, be);
        check("t2a_taken", {31'd0, taken}, 32'd1);
        run_seq(mk_ir(BOP, 2'b01), 32'd0, 0, 1'b0, lat, sd, si, reads, be);
        check("t2b_taken", {31'd0, taken}, 32'd0);
        check("t2b_latency", lat, LAT_NT);

        // 3: sign conditions
        run_seq(mk_ir(BOP, 2'b11), 32'h8000_0000, 0, 1'b0, lat, sd, si, reads, be);
        check("t3a_taken", {31'd0, taken}, 32'd1);
        run_seq(mk_ir(BOP, 2'b10), 32'hFFFF_FFFF, 0, 1'b0, lat, sd, si, reads, be);
        check("t3b_taken", {31'd0, taken}, 32'd0);
        run_seq(mk_ir(BOP, 2'b10), 32'h7FFF_FFFF, 0, 1'b0, lat, sd, si, reads, be);
        check("t3c_taken", {31'd0, taken}, 32'd1);

        // 4: memory stall of three cycles
        run_seq(mk_ir(BOP, 2'b00), 32'h0, 3, 1'b0, lat, sd, si, reads, be);
        check("t4_read_cycles", reads, 4);
        check("t4_latency", lat, 11);
        check("t4_taken", {31'd0, taken}, 32'd1);

        // 5: illegal opcode keeps taken = 1 from the previous branch
        run_seq(mk_ir(5'b00000, 2'b01), 32'h0, 0, 1'b0, lat, sd, si, reads, be);
        check("t5_illegal", {31'd0, si}, 32'd1);
        check("t5_no_done", {31'd0, sd}, 32'd0);
        check("t5_latency", lat, 5);
        check("t5_busy_low", {31'd0, be}, 32'd0);
        check("t5_taken_kept", {31'd0, taken}, 32'd1);

        // 6: start pulses while busy and in DONE are ignored
        run_seq(mk_ir(BOP, 2'b11), 32'h1, 0, 1'b1, lat, sd, si, reads, be);
        check("t6_latency", lat, LAT_NT);
        check("t6_taken", {31'd0, taken}, 32'd0);

        // 6b: asynchronous Clear in the middle of T4
        run_seq(mk_ir(BOP, 2'b01), 32'h9, 0, 1'b0, lat, sd, si, reads, be);
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        repeat (4) @(negedge Clock);
        check("pre_clear_yin", {31'd0, Yin}, 32'd1);
        #2 Clear = 1'b1;
        #1 check("clear_async", {14'd0, act_vec()}, 32'd0);
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        check("clear_held", {14'd0, act_vec()}, 32'd0);
        #2 Clear = 1'b0;
        repeat (3) @(negedge Clock);
        check("idle_after_clear", {30'd0, busy, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
